fifo_window_reducer: RTL

- Downstream consumer of a 16-bit `fifo` instance, such as the result FIFO written by a `vhls_target` kernel.
- Drains words from the FIFO using the FIFO's read handshake and groups them into fixed-size windows of WINDOW words.
- For each window it produces the sum, maximum and minimum, and presents them on a valid/ready result port.
- It is the standard sink used to reduce kernel output streams to checkable summaries.

---
 rtl/fifo_window_reducer_if.sv | 37 +++
 rtl/fifo_window_reducer.sv | 110 +++++++++++
 2 files changed

// File: rtl/fifo_window_reducer_if.sv
// Port bundle for fifo_window_reducer: the upstream fifo read side and the
// downstream result port.
//
// Handshakes:
//   - Upstream: in_read_valid is a pop request and is only ever raised while
//     in_read_ready (fifo non-empty) is high. The popped word appears on
//     in_out_data one cycle after the pop.
//   - Downstream: a result transfers at a rising edge where out_valid and
//     out_ready are both high. Once out_valid rises, out_sum/out_max/out_min
//     stay stable until that transfer. out_ready has no effect while
//     out_valid is low.
interface fifo_window_reducer_if #(
  parameter int WIDTH     = 16,
  parameter int SUM_WIDTH = 24
);
  logic [WIDTH-1:0]     in_out_data;
  logic                 in_read_ready;
  logic                 in_read_valid;
  logic [SUM_WIDTH-1:0] out_sum;
  logic [WIDTH-1:0]     out_max;
  logic [WIDTH-1:0]     out_min;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          window_count;

  // Reducer side
  modport master (
    input  in_out_data, in_read_ready, out_ready,
    output in_read_valid, out_sum, out_max, out_min, out_valid, window_count
  );

  // Environment side: upstream fifo plus downstream consumer
  modport slave (
    output in_out_data, in_read_ready, out_ready,
    input  in_read_valid, out_sum, out_max, out_min, out_valid, window_count
  );
endinterface

// File: rtl/fifo_window_reducer.sv
// Drains words from an upstream fifo and reduces each group of WINDOW words
// to its sum, maximum and minimum, presented on a valid/ready result port.
module fifo_window_reducer #(
  parameter int WIDTH     = 16,
  parameter int WINDOW    = 4,
  parameter int SUM_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_window_reducer_if.master bus,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    POP  = 2'd0,
    CAPT = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [SUM_WIDTH-1:0] acc;
  logic [WIDTH-1:0]     run_max;
  logic [WIDTH-1:0]     run_min;

  logic [CNT_W-1:0]     cnt_inc;
  logic [SUM_WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]     max_nxt;
  logic [WIDTH-1:0]     min_nxt;
  logic                 window_done;
  logic                 handshake;

  // Running reductions with the word currently on the fifo output folded in
  always_comb begin
    cnt_inc     = cnt + 1'b1;
    acc_nxt     = acc + SUM_WIDTH'(bus.in_out_data);
    max_nxt     = (bus.in_out_data > run_max) ? bus.in_out_data : run_max;
    min_nxt     = (bus.in_out_data < run_min) ? bus.in_out_data : run_min;
    window_done = (cnt_inc == CNT_W'(WINDOW));
    handshake   = bus.out_valid & bus.out_ready;
  end

  // Next state and pop request; no pop is issued while reset is asserted
  always_comb begin
    state_nxt         = state;
    bus.in_read_valid = 1'b0;
    case (state)
      POP: begin
        if (bus.in_read_ready) begin
          bus.in_read_valid = ~rst;
          state_nxt         = CAPT;
        end
      end
      CAPT: state_nxt = window_done ? EMIT : POP;
      EMIT: begin
        if (handshake) state_nxt = POP;
      end
      default: state_nxt = POP;
    endcase
  end

  // State register, accumulators and registered result port
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= POP;
      cnt              <= '0;
      acc              <= '0;
      run_max          <= '0;
      run_min          <= '1;
      bus.out_valid    <= 1'b0;
      bus.out_sum      <= '0;
      bus.out_max      <= '0;
      bus.out_min      <= '0;
      bus.window_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        CAPT: begin
          cnt     <= cnt_inc;
          acc     <= acc_nxt;
          run_max <= max_nxt;
          run_min <= min_nxt;
          if (window_done) begin
            bus.out_sum   <= acc_nxt;
            bus.out_max   <= max_nxt;
            bus.out_min   <= min_nxt;
            bus.out_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (handshake) begin
            bus.out_valid    <= 1'b0;
            bus.window_count <= bus.window_count + 16'd1;
            cnt              <= '0;
            acc              <= '0;
            run_max          <= '0;
            run_min          <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
